// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Two-channel pushbutton front end. Each raw button level is
//               synchronized, debounced over DEBOUNCE_TICKS sample ticks and
//               turned into a single registered shift pulse per press. A
//               press accepted on both channels in the same cycle is reported
//               as a conflict instead of as two shift pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  output logic shift_left,
  output logic shift_right,
  output logic left_level,
  output logic right_level,
  output logic conflict
);

  // Counter only has to reach DEBOUNCE_TICKS-1; never narrower than one bit.
  localparam int CW = (DEBOUNCE_TICKS <= 2) ? 1 : $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

  // Channel 0 is left, channel 1 is right.
  logic [1:0] w_raw;
  logic [1:0] w_level;

  assign w_raw = {btn_right_raw, btn_left_raw};

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic          r_sync1;
      logic          r_sync2;
      logic [CW-1:0] r_cnt;
      logic          r_level;

      // Two-flop synchronizer for the asynchronous button level.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= w_raw[ch];
          r_sync2 <= r_sync1;
        end
      end

      // Debounce: accept a new level only after DEBOUNCE_TICKS consecutive
      // ticked samples disagree with it; any agreeing sample restarts the run.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (sample_tick) begin
          if (r_sync2 == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == C_CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      assign w_level[ch] = r_level;
    end
  endgenerate

  assign left_level  = w_level[0];
  assign right_level = w_level[1];

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  state_t r_state_l;
  state_t r_state_r;
  logic   r_shift_left;
  logic   r_shift_right;
  logic   r_conflict;
  logic   w_rise_l;
  logic   w_rise_r;

  // A press is taken when a channel still idles but its debounced level is high.
  assign w_rise_l = (r_state_l == ST_IDLE) && w_level[0];
  assign w_rise_r = (r_state_r == ST_IDLE) && w_level[1];

  // One-pulse FSMs for both channels plus their registered pulse outputs;
  // kept together because a simultaneous press steers both into WAIT_REL.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_l     <= ST_IDLE;
      r_state_r     <= ST_IDLE;
      r_shift_left  <= 1'b0;
      r_shift_right <= 1'b0;
      r_conflict    <= 1'b0;
    end else begin
      r_shift_left  <= w_rise_l && !w_rise_r;
      r_shift_right <= w_rise_r && !w_rise_l;
      r_conflict    <= w_rise_l && w_rise_r;

      case (r_state_l)
        ST_IDLE:     if (w_level[0]) r_state_l <= w_rise_r ? ST_WAIT_REL : ST_ARMED;
        ST_ARMED,
        ST_WAIT_REL: if (!w_level[0]) r_state_l <= ST_IDLE;
        default:     r_state_l <= ST_IDLE;
      endcase

      case (r_state_r)
        ST_IDLE:     if (w_level[1]) r_state_r <= w_rise_l ? ST_WAIT_REL : ST_ARMED;
        ST_ARMED,
        ST_WAIT_REL: if (!w_level[1]) r_state_r <= ST_IDLE;
        default:     r_state_r <= ST_IDLE;
      endcase
    end
  end

  assign shift_left  = r_shift_left;
  assign shift_right = r_shift_right;
  assign conflict    = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner with a per-cycle
//               behavioural model and directed press/bounce/reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int D = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b1;
  logic btn_left_raw = 1'b0;
  logic btn_right_raw = 1'b0;
  logic shift_left, shift_right, left_level, right_level, conflict;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit gate = 1'b0;

  // Pulse bookkeeping observed on the DUT
  int n_sl = 0, n_sr = 0, n_cf = 0;
  int last_sl = -1, last_sr = -1, last_cf = -1;

  button_conditioner #(.DEBOUNCE_TICKS(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .btn_left_raw (btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .shift_left   (shift_left),
    .shift_right  (shift_right),
    .left_level   (left_level),
    .right_level  (right_level),
    .conflict     (conflict)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Sample enable: every cycle, or one cycle in 32 when gating.
  initial forever begin
    @(posedge clock);
    #1;
    sample_tick = gate ? ((cyc % 32) == 0) : 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: the debounced level flips once the last D ticked
  // synchronized samples (all taken since the previous flip) disagree with it.
  // A press is a 0->1 step of the debounced level; it becomes a shift pulse
  // one cycle later unless both channels step up together.
  bit         m_s1 [2];
  bit         m_s2 [2];
  bit         m_lvl [2];
  bit         m_lvlp [2];
  int         m_since [2];
  logic [255:0] m_hist [2];
  bit e_sl, e_sr, e_cf, e_ll, e_rl;
  bit armed = 1'b0;

  initial forever begin
    bit raw [2];
    bit rl, rr, ok;
    @(negedge clock);
    if (armed) begin
      chk("shift_left",  shift_left,  e_sl);
      chk("shift_right", shift_right, e_sr);
      chk("conflict",    conflict,    e_cf);
      chk("left_level",  left_level,  e_ll);
      chk("right_level", right_level, e_rl);
      if (shift_left && shift_right) chk("both_shifts", 1, 0);
    end
    if (shift_left)  begin n_sl++; last_sl = cyc; end
    if (shift_right) begin n_sr++; last_sr = cyc; end
    if (conflict)    begin n_cf++; last_cf = cyc; end

    // Advance the model across the coming edge with the inputs now applied.
    raw[0] = btn_left_raw;
    raw[1] = btn_right_raw;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_lvlp[c] = 0;
        m_since[c] = 0; m_hist[c] = '0;
      end
      e_sl = 0; e_sr = 0; e_cf = 0;
    end else begin
      rl = m_lvl[0] && !m_lvlp[0];
      rr = m_lvl[1] && !m_lvlp[1];
      e_sl = rl && !rr;
      e_sr = rr && !rl;
      e_cf = rl && rr;
      for (int c = 0; c < 2; c++) begin
        m_lvlp[c] = m_lvl[c];
        if (sample_tick) begin
          m_hist[c] = {m_hist[c][254:0], m_s2[c]};
          m_since[c]++;
          ok = (m_since[c] >= D);
          for (int i = 0; i < D; i++)
            if (m_hist[c][i] == m_lvl[c]) ok = 0;
          if (ok) begin
            m_lvl[c] = !m_lvl[c];
            m_since[c] = 0;
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
    e_ll = m_lvl[0];
    e_rl = m_lvl[1];
    armed = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int t0, b_sl, b_sr, b_cf;

    // Reset state
    step(3);
    chk("rst_shift_left", shift_left, 0);
    chk("rst_left_level", left_level, 0);
    chk("rst_conflict", conflict, 0);
    reset = 1'b0;
    step(5);

    // Clean left press held 30 cycles
    t0 = cyc; b_sl = n_sl;
    btn_left_raw = 1'b1;
    step(5);
    chk("clean_level_c5", left_level, 0);
    step(1);
    chk("clean_level_c6", left_level, 1);
    step(24);
    chk("clean_pulses", n_sl - b_sl, 1);
    chk("clean_pulse_cycle", last_sl, t0 + 7);
    btn_left_raw = 1'b0;
    step(15);
    chk("clean_release_pulses", n_sl - b_sl, 1);

    // Bouncing right button, then stable high
    b_sr = n_sr;
    btn_right_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(2);
      btn_right_raw = ~btn_right_raw;
    end
    t0 = cyc;
    chk("bounce_no_early_pulse", n_sr - b_sr, 0);
    step(20);
    chk("bounce_pulses", n_sr - b_sr, 1);
    chk("bounce_pulse_cycle", last_sr, t0 + 7);
    btn_right_raw = 1'b0;
    step(15);

    // Simultaneous press, then separate presses
    t0 = cyc; b_sl = n_sl; b_sr = n_sr; b_cf = n_cf;
    btn_left_raw = 1'b1;
    btn_right_raw = 1'b1;
    step(20);
    chk("sim_conflicts", n_cf - b_cf, 1);
    chk("sim_conflict_cycle", last_cf, t0 + 7);
    chk("sim_left_pulses", n_sl - b_sl, 0);
    chk("sim_right_pulses", n_sr - b_sr, 0);
    btn_left_raw = 1'b0;
    btn_right_raw = 1'b0;
    step(15);
    btn_left_raw = 1'b1;
    step(15);
    btn_right_raw = 1'b1;
    step(15);
    chk("sep_left_pulses", n_sl - b_sl, 1);
    chk("sep_right_pulses", n_sr - b_sr, 1);
    chk("sep_conflicts", n_cf - b_cf, 1);
    btn_left_raw = 1'b0;
    btn_right_raw = 1'b0;
    step(15);

    // Sparse sample ticks
    gate = 1'b1;
    b_sl = n_sl;
    step(2);
    btn_left_raw = 1'b1;
    step(32 * 2);
    chk("gate_level_early", left_level, 0);
    step(32 * 4);
    chk("gate_pulses", n_sl - b_sl, 1);
    chk("gate_level", left_level, 1);
    btn_left_raw = 1'b0;
    step(32 * 6);
    chk("gate_release_level", left_level, 0);
    gate = 1'b0;
    step(5);

    // Reset while held after the pulse was issued
    btn_left_raw = 1'b1;
    step(12);
    reset = 1'b1;
    step(1);
    chk("midrst_level", left_level, 0);
    chk("midrst_shift", shift_left, 0);
    step(2);
    reset = 1'b0;
    t0 = cyc; b_sl = n_sl;
    step(20);
    chk("midrst_pulses", n_sl - b_sl, 1);
    chk("midrst_pulse_cycle", last_sl, t0 + 7);
    btn_left_raw = 1'b0;
    step(15);

    // Short release glitch while accepted
    btn_left_raw = 1'b1;
    step(12);
    b_sl = n_sl;
    btn_left_raw = 1'b0;
    step(2);
    btn_left_raw = 1'b1;
    step(15);
    chk("glitch_level", left_level, 1);
    chk("glitch_pulses", n_sl - b_sl, 0);
    btn_left_raw = 1'b0;
    step(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
